// File: rtl/jsv_spi_pkg.sv
// Shared types and command-byte field positions for the SPI register responder.
package jsv_spi_pkg;
  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  localparam int   CMD_ADDR_MSB = 7;
  localparam int   CMD_ADDR_LSB = 3;
  localparam int   CMD_DIR_BIT  = 1;
  localparam logic SPI_WRITE    = 1'b1;
  localparam logic SPI_READ     = 1'b0;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with one-cycle rise/fall event outputs for one SPI pin.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      prev <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder exposing a byte register file; all pins oversampled on clk_clk.
// Optional SPI_RESP_IRQ_EN adds irq_n driven from status_i masked by the top register.
module spi_reg_responder
  import jsv_spi_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              spi_SCLK,
  input  logic              spi_SS_n,
  input  logic              spi_MOSI,
  output logic              spi_MISO,
  output logic              spi_MISO_oe,
  input  logic [7:0]        status_i,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic              loc_we,
  input  logic [7:0]        loc_wdata,
  output logic [7:0]        loc_rdata,
  output logic              wr_pulse,
  output logic [ADDR_W-1:0] wr_addr
`ifdef SPI_RESP_IRQ_EN
  ,
  output logic              irq_n
`endif
);
  localparam int NUM_REGS = 2**ADDR_W;

  logic [7:0]        regs [NUM_REGS];
  state_t            state;
  logic [2:0]        bit_cnt;
  logic [7:0]        rx_sh, tx_sh, nxt_byte;
  logic [ADDR_W-1:0] addr;
  logic              dir;

  logic sclk_q, sclk_rise, sclk_fall;
  logic ss_q, ss_rise, ss_fall;
  logic mosi_q, mosi_rise, mosi_fall;
  logic unused_ok;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk_clk), .rst_n(reset_reset_n), .din(spi_SCLK),
    .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk(clk_clk), .rst_n(reset_reset_n), .din(spi_SS_n),
    .q(ss_q), .rise(ss_rise), .fall(ss_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk_clk), .rst_n(reset_reset_n), .din(spi_MOSI),
    .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall));

  assign unused_ok = &{1'b0, sclk_q, ss_rise, mosi_rise, mosi_fall};

  // Byte as it stands once the current rising edge's bit is shifted in.
  logic [7:0]                           rx_byte;
  logic [CMD_ADDR_MSB-CMD_ADDR_LSB:0]   cmd_field;
  logic [ADDR_W-1:0]                    nxt_addr;
  logic                                 nxt_dir;

  assign rx_byte   = {rx_sh[6:0], mosi_q};
  assign cmd_field = rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
  assign nxt_addr  = (state == CMD) ? cmd_field[ADDR_W-1:0] : addr + 1'b1;
  assign nxt_dir   = (state == CMD) ? rx_byte[CMD_DIR_BIT] : dir;

  assign spi_MISO  = tx_sh[7];
  assign loc_rdata = regs[loc_addr];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_sh       <= '0;
      tx_sh       <= '0;
      nxt_byte    <= '0;
      addr        <= '0;
      dir         <= SPI_READ;
      spi_MISO_oe <= 1'b0;
      wr_pulse    <= 1'b0;
      wr_addr     <= '0;
    end else begin
      wr_pulse <= 1'b0;
      if (loc_we) regs[loc_addr] <= loc_wdata;
      // Deselect drops any partial byte; the SPI write below overrides a colliding local write.
      if (ss_q) begin
        state       <= IDLE;
        bit_cnt     <= '0;
        tx_sh       <= '0;
        spi_MISO_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: if (ss_fall) begin
            state       <= CMD;
            bit_cnt     <= '0;
            tx_sh       <= status_i;
            spi_MISO_oe <= 1'b1;
          end
          CMD, DATA: begin
            if (sclk_rise) begin
              rx_sh   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (state == DATA && dir == SPI_WRITE) begin
                  regs[addr] <= rx_byte;
                  wr_pulse   <= 1'b1;
                  wr_addr    <= addr;
                end
                state    <= DATA;
                addr     <= nxt_addr;
                dir      <= nxt_dir;
                nxt_byte <= (nxt_dir == SPI_READ) ? regs[nxt_addr] : 8'h00;
              end
            end else if (sclk_fall) begin
              tx_sh <= (bit_cnt == 3'd0) ? nxt_byte : {tx_sh[6:0], 1'b0};
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SPI_RESP_IRQ_EN
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) irq_n <= 1'b1;
    else                irq_n <= ~|(status_i & regs[NUM_REGS-1]);
  end
`endif
endmodule
